demux4_dispatch: RTL

Sequencing controller for the 1:4 demultiplexer datapath. It accepts a single valid/ready input stream and dispatches beats to four output channels in bursts of BURST beats per channel. Channels are visited in round-robin order, skipping any channel masked off by en_mask. It owns the demux select, a one-beat output register and the burst counter, so downstream consumers see a clean per-channel valid/ready handshake.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux4_dispatch_if.sv | 25 ++
 rtl/rr_next_sel.sv | 28 ++
 rtl/demux4_dispatch.sv | 99 +++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the demux dispatch family.
// Holds channel count, select width and the holding-register state encoding.
package demux_pkg;

   localparam int NCH  = 4;
   localparam int SELW = 2;

   typedef logic [SELW-1:0] sel_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/demux4_dispatch_if.sv
// Handshake bundle for demux4_dispatch: one valid/ready input stream and
// the shared data / one-hot valid / per-channel ready output side.
interface demux4_dispatch_if #(
   parameter int W = 8
);
   import demux_pkg::*;

   logic           in_valid;
   logic [W-1:0]   in_data;
   logic           in_ready;
   logic [W-1:0]   y_data;
   logic [NCH-1:0] y_valid;
   logic [NCH-1:0] y_ready;

   modport master (
      output in_valid, in_data, y_ready,
      input  in_ready, y_data, y_valid
   );

   modport slave (
      input  in_valid, in_data, y_ready,
      output in_ready, y_data, y_valid
   );

endinterface

// File: rtl/rr_next_sel.sv
// Round-robin channel search: cur+1, cur+2, cur+3, then cur itself.
// Ports: cur (current index), mask (enables) -> nxt (first enabled), none.
module rr_next_sel
   import demux_pkg::*;
(
   input  sel_t           cur,
   input  logic [NCH-1:0] mask,
   output sel_t           nxt,
   output logic           none
);

   sel_t idx;

   // Walk from the farthest candidate to the nearest so that the
   // nearest enabled channel is the last one written.
   always_comb begin
      nxt  = cur;
      none = (mask == '0);
      idx  = cur;
      for (int k = NCH; k >= 1; k--) begin
         idx = cur + sel_t'(k);
         if (mask[idx]) begin
            nxt = idx;
         end
      end
   end

endmodule

// File: rtl/demux4_dispatch.sv
// Burst round-robin dispatcher: one input stream fanned out to four channels
// through a one-beat register, BURST beats per channel, skipping masked ones.
// Ports: clk, rst (async, high), en_mask, io (slave handshake bundle),
//        sel (channel pointer), burst_done (last beat of a burst delivered).
module demux4_dispatch
   import demux_pkg::*;
#(
   parameter int W     = 8,
   parameter int BURST = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] en_mask,
   demux4_dispatch_if.slave io,
   output sel_t           sel,
   output logic           burst_done
);

   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CW-1:0] LAST = CW'(BURST - 1);

   state_t         state;
   state_t         state_nx;
   sel_t           sel_nx;
   sel_t           sel_fwd;
   sel_t           rr_nxt;
   logic           rr_none;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nx;
   logic [W-1:0]   dreg;
   logic           live;
   logic           out_fire;
   logic           in_fire;
   logic           last;
   logic           fix;

   rr_next_sel u_rr (
      .cur  (sel),
      .mask (en_mask),
      .nxt  (rr_nxt),
      .none (rr_none)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
         sel   <= '0;
         cnt   <= '0;
         dreg  <= '0;
         live  <= 1'b0;
      end else begin
         state <= state_nx;
         sel   <= sel_nx;
         cnt   <= cnt_nx;
         live  <= 1'b1;
         if (in_fire) begin
            dreg <= io.in_data;
         end
      end
   end

   always_comb begin
      out_fire   = (state == FULL) && io.y_ready[sel];
      last       = (cnt == LAST);
      burst_done = out_fire && last;

      // Pointer the next accepted beat will be tagged with.
      sel_fwd = (burst_done && !rr_none) ? rr_nxt : sel;

      // live keeps in_ready low until the first edge after reset.
      io.in_ready = live && en_mask[sel_fwd]
                    && ((state == EMPTY) || out_fire);
      in_fire = io.in_valid && io.in_ready;

      // Idle pointer parked on a disabled channel: hop, costs one cycle.
      fix = (state == EMPTY) && !en_mask[sel] && !rr_none;

      state_nx = state;
      unique case (state)
         EMPTY: if (in_fire) state_nx = FULL;
         FULL:  if (out_fire && !in_fire) state_nx = EMPTY;
         default: state_nx = EMPTY;
      endcase

      sel_nx = sel;
      cnt_nx = cnt;
      if (out_fire) begin
         sel_nx = sel_fwd;
         cnt_nx = last ? '0 : cnt + 1'b1;
      end else if (fix) begin
         sel_nx = rr_nxt;
         cnt_nx = '0;
      end
   end

   assign io.y_data  = dreg;
   assign io.y_valid = (state == FULL) ? (NCH'(1) << sel) : '0;

endmodule
